// File: rtl/icache_param.sv
// Direct-mapped, read-only instruction cache with configurable geometry,
// multi-word block fill, whole-cache invalidate and saturating hit/miss counters.
module icache_param #(
  parameter int NSETS = 16,
  parameter int WPB   = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             inval,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             dbg_state_o
);
  localparam int IDX_W = $clog2(NSETS);
  localparam int OFF_W = $clog2(WPB);
  localparam int OW    = (OFF_W > 0) ? OFF_W : 1;
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OW-1:0] LAST_WORD = OW'(WPB - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  // Handshake: the memory side accepts a word on any cycle with iREN=1 and
  // iwait=0; iREN stays high for the whole fill and iaddr advances after each accept.
  state_e            state_q;
  logic [NSETS-1:0]  valid_q;
  logic [OW-1:0]     cnt_q;
  logic              pend_q;
  logic [CNT_W-1:0]  hit_q, miss_q;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [31:0]       data_q [NSETS][WPB];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [OW-1:0]     req_off;
  logic              tag_match, miss_start, word_acc, fill_done;
  logic              unused_addr_bits;

  assign req_idx = imemaddr[2+OFF_W +: IDX_W];
  assign req_tag = imemaddr[31 -: TAG_W];
  assign unused_addr_bits = ^imemaddr[1:0];

  always_comb begin
    req_off = '0;
    if (OFF_W > 0) req_off = imemaddr[2 +: OW];
  end

  assign tag_match  = (tag_q[req_idx] == req_tag);
  assign imemload   = data_q[req_idx][req_off];
  assign ihit       = imemREN && (state_q == IDLE) && valid_q[req_idx] && tag_match && !inval;
  assign miss_start = (state_q == IDLE) && imemREN && !inval && !ihit;
  assign word_acc   = (state_q == FILL) && !iwait;
  assign fill_done  = word_acc && (cnt_q == LAST_WORD);

  assign iREN        = (state_q == FILL);
  assign iaddr       = (state_q == FILL)
                     ? ((32'({miss_tag_q, miss_idx_q}) << (OFF_W + 2)) | (32'(cnt_q) << 2))
                     : 32'h0;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (ihit && (hit_q != '1)) hit_q <= hit_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (inval) begin
            valid_q <= '0;
          end else if (miss_start) begin
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= FILL;
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
          end
        end
        FILL: begin
          if (inval) pend_q <= 1'b1;
          if (fill_done) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            // An invalidate seen at any point of the fill also kills the new line.
            if (pend_q || inval) valid_q <= '0;
            else                 valid_q[miss_idx_q] <= 1'b1;
          end else if (word_acc) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge CLK) begin
    if (!RST && miss_start) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
    end
    if (!RST && word_acc)  data_q[miss_idx_q][cnt_q] <= iload;
    if (!RST && fill_done) tag_q[miss_idx_q] <= miss_tag_q;
  end
endmodule
